// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and default bit timing
// (100 MHz core clock at 115200 baud).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam int DefaultClksPerBit = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..ClksPerBit-1 while enabled, ticks on the last count.
// Clear has priority over enable so a new bit always starts from a full period.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int ClksPerBit = DefaultClksPerBit
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   localparam int              CntW    = $clog2(ClksPerBit);
   localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_enable) begin
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_tick = i_enable && (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word from an external FIFO, then sends start, LSB-first data
// and stop bits; frames run back to back with a 2-cycle gap (pop + fetch) between them.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DataWidth  = 8,
   parameter int ClksPerBit = DefaultClksPerBit
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fifo_empty,
   input  logic [DataWidth-1:0] i_fifo_data,
   output logic                 o_fifo_rd_en,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int              IdxW    = $clog2(DataWidth);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(DataWidth - 1);

   tx_state_e            state_q, state_d;
   logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 baud_tick;
   logic                 baud_clear;
   logic                 baud_en;

   uart_baud_cnt #(
      .ClksPerBit(ClksPerBit)
   ) u_baud_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (baud_clear),
      .i_enable(baud_en),
      .o_tick  (baud_tick)
   );

   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      o_fifo_rd_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Gated by reset so nothing is popped while the block is held in reset.
            if (!i_fifo_empty && i_rst_n) begin
               o_fifo_rd_en = 1'b1;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            shift_d = i_fifo_data;
            state_d = START;
         end
         START: begin
            if (baud_tick) state_d = DATA;
         end
         DATA: begin
            if (baud_tick) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + IdxW'(1);
               if (bit_idx_q == IdxLast) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) bit_idx_d = '0;

      // Line level is precomputed for the next state so o_tx comes straight from a flop.
      tx_d = 1'b1;
      if (state_d == START) begin
         tx_d = 1'b0;
      end else if (state_d == DATA) begin
         tx_d = shift_d[0];
      end
   end

   assign baud_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
   assign baud_clear = (state_d != state_q);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = o_fifo_rd_en || (state_q != IDLE);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DataWidth, default 8, number of data bits per frame and width of the FIFO read data.
REQ-002 Parameter ClksPerBit, default 868, i_clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_fifo_empty  input  1  TX FIFO empty flag from the FIFO controller.
REQ-006 i_fifo_data  input  DataWidth  FIFO head data; valid one cycle after o_fifo_rd_en is sampled high.
REQ-007 o_fifo_rd_en  output  1  single-cycle pop strobe to the FIFO controller.
REQ-008 o_tx  output  1  serial line; idle high.
REQ-009 o_busy  output  1  high from the pop cycle through the last stop-bit cycle.

Function
REQ-010 FSM states SHALL be IDLE, FETCH, START, DATA, STOP.
REQ-011 In IDLE with i_fifo_empty=0, o_fifo_rd_en SHALL be 1 for exactly that cycle, and the next state SHALL be FETCH.
REQ-012 In IDLE with i_fifo_empty=1, o_fifo_rd_en SHALL be 0 and the state SHALL remain IDLE.
REQ-013 o_fifo_rd_en SHALL be 0 in every state other than IDLE; the block SHALL never pop an empty FIFO.
REQ-014 In FETCH, i_fifo_data SHALL be latched into the shift register, and the next state SHALL be START.
REQ-015 START SHALL drive o_tx=0 for exactly ClksPerBit cycles.
REQ-016 DATA SHALL drive DataWidth bits LSB first, each for exactly ClksPerBit cycles.
REQ-017 STOP SHALL drive o_tx=1 for exactly ClksPerBit cycles, then return to IDLE.
REQ-018 o_tx SHALL be 1 in IDLE and FETCH.
REQ-019 o_tx SHALL be driven from a register, with no combinational path from inputs.
REQ-020 Baud counter width SHALL be $clog2(ClksPerBit).
REQ-021 The baud counter SHALL count 0..ClksPerBit-1, reset to 0 on every state change, and generate the bit-end tick at ClksPerBit-1.
REQ-022 Bit index width SHALL be $clog2(DataWidth); DATA SHALL exit after index DataWidth-1 completes.
REQ-023 Back-to-back frames: the gap between the end of the stop bit and the next start bit SHALL be exactly 2 idle-high cycles (IDLE pop + FETCH).
REQ-024 A frame length SHALL be (DataWidth+2)*ClksPerBit cycles from the first START cycle to the last STOP cycle.
REQ-025 i_fifo_empty and i_fifo_data changes during START/DATA/STOP SHALL have no effect on the frame in flight.
REQ-026 o_busy SHALL be 1 in the IDLE cycle that pops and in FETCH/START/DATA/STOP, and 0 otherwise.

Reset
REQ-027 While i_rst_n=0 at a clock edge, the outputs SHALL be state=IDLE, o_tx=1, o_busy=0, o_fifo_rd_en=0, with baud counter, bit index and shift register all 0.
REQ-028 On reset mid-frame, o_tx SHALL be 1 the cycle after the reset edge; the popped byte is discarded and not retransmitted.
REQ-029 The first pop after reset release SHALL occur no earlier than the first cycle with i_rst_n=1 and i_fifo_empty=0.

Structure
REQ-030 Package uart_pkg SHALL hold the tx_state_e enum (IDLE, FETCH, START, DATA, STOP) and the DefaultClksPerBit constant (868).
REQ-031 Baud timing SHALL be one sub-module, uart_baud_cnt (parameter ClksPerBit, inputs clear/enable, output tick), reusable by the receiver.
REQ-032 All other logic SHALL reside in uart_tx, and the FIFO storage and pointers SHALL remain outside this block.

Verification (ClksPerBit=4, DataWidth=8 unless stated)
REQ-033 Single byte: FIFO holds 0x55 -> one rd_en pulse, then o_tx = 0 (4 cycles), bits 1,0,1,0,1,0,1,0 (4 cycles each), 1 (4 cycles); total 40 cycles low-to-stop-end.
REQ-034 Empty FIFO: i_fifo_empty=1 for 100 cycles -> o_fifo_rd_en never 1, o_tx constant 1, o_busy 0.
REQ-035 Back-to-back: FIFO holds 0x00, 0xFF -> exactly 2 rd_en pulses; exactly 2 high cycles between the first stop bit end and the second start bit.
REQ-036 Reset mid-frame: assert i_rst_n=0 during bit 3 of 0xA5 -> o_tx=1 next cycle, o_busy=0; after release with FIFO empty, no frame is sent.
REQ-037 Input stability: toggle i_fifo_data and i_fifo_empty randomly during frame 0x3C -> received byte = 0x3C, with no extra rd_en pulse before STOP ends.
REQ-038 Parameter sweep: ClksPerBit=2 and DataWidth=7, byte 0x41 -> 18-cycle frame, 7 data bits LSB first, decoded by the bench UART model without error.
